// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the pipeline: opcodes, field positions, operand-use
// decode and the interlock FSM state type.
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS1_HI = 9;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 6;

    localparam logic [15:0] NOP_INS = 16'h0000;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    function automatic logic writes_rd(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_LD, OP_MOV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST, OP_MOV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot destination tracker for the EXE, DM and WB stages.
// Slot index 0 = EXE, 1 = DM, 2 = WB; all slots shift every cycle.
module hazard_scoreboard
    import cpu_isa_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            new_vld_i,
    input  logic [1:0]      new_rd_i,
    output logic [2:0]      slot_vld_o,
    output logic [2:0][1:0] slot_rd_o
);

    logic [2:0]      vld_q;
    logic [2:0][1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            rd_q  <= '0;
        end else begin
            vld_q <= {vld_q[1:0], new_vld_i};
            rd_q  <= {rd_q[1:0], new_rd_i};
        end
    end

    assign slot_vld_o = vld_q;
    assign slot_rd_o  = rd_q;

endmodule

// File: rtl/hazard_unit.sv
// Read-after-write interlock: holds IF/ID and the PC and injects NOPs into
// ID/EXE until every operand of the instruction in ID is readable.
module hazard_unit
    import cpu_isa_pkg::*;
#(
    parameter bit WB_WRITE_THROUGH = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      id_ins,
    input  logic             id_valid,
    output logic             if_id_we,
    output logic             pc_we,
    output logic             bubble,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] stall_events
);

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       unused_bits;

    assign op          = id_ins[OPC_HI:OPC_LO];
    assign rd          = id_ins[RD_HI:RD_LO];
    assign rs1         = id_ins[RS1_HI:RS1_LO];
    assign rs2         = id_ins[RS2_HI:RS2_LO];
    assign unused_bits = ^id_ins[5:0];

    logic [2:0]      slot_vld;
    logic [2:0][1:0] slot_rd;
    logic            hazard;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // The WB slot only matters when the register file cannot forward
            // a same-cycle write to the ID read.
            if (slot_vld[i] && (i < 2 || !WB_WRITE_THROUGH)) begin
                if ((reads_rs1(op) && rs1 == slot_rd[i]) ||
                    (reads_rs2(op) && rs2 == slot_rd[i])) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard = hazard & id_valid;
    end

    assign bubble   = !rst_n || hazard;
    assign if_id_we = rst_n && !hazard;
    assign pc_we    = if_id_we;

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_vld_i  (writes_rd(op) && id_valid && !bubble),
        .new_rd_i   (rd),
        .slot_vld_o (slot_vld),
        .slot_rd_o  (slot_rd)
    );

    hz_state_e        state_q;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] events_q, events_d;

    always_comb begin
        cycles_d = cycles_q;
        events_d = events_q;
        if (bubble && cycles_q != '1) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
        if (state_q == RUN && hazard && events_q != '1) begin
            events_d = events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cycles_q <= '0;
            events_q <= '0;
        end else begin
            state_q  <= hazard ? STALL : RUN;
            cycles_q <= cycles_d;
            events_q <= events_d;
        end
    end

    assign stalled      = (state_q == STALL);
    assign stall_cycles = cycles_q;
    assign stall_events = events_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: write-through, no-write-through and
// narrow-counter instances, each with hand-computed bubble counts.
module tb_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] ins_v [3];
    logic        val_v [3];
    logic        bub_v [3];
    logic        we_v  [3];
    logic        pc_v  [3];
    logic        stl_v [3];
    logic [15:0] a_sc, a_se, b_sc, b_se;
    logic [1:0]  c_sc, c_se;

    int n_cmp;
    int n_err;

    hazard_unit u_a (
        .clk(clk), .rst_n(rst_n), .id_ins(ins_v[0]), .id_valid(val_v[0]),
        .if_id_we(we_v[0]), .pc_we(pc_v[0]), .bubble(bub_v[0]),
        .stalled(stl_v[0]), .stall_cycles(a_sc), .stall_events(a_se)
    );

    hazard_unit #(.WB_WRITE_THROUGH(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .id_ins(ins_v[1]), .id_valid(val_v[1]),
        .if_id_we(we_v[1]), .pc_we(pc_v[1]), .bubble(bub_v[1]),
        .stalled(stl_v[1]), .stall_cycles(b_sc), .stall_events(b_se)
    );

    hazard_unit #(.CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .id_ins(ins_v[2]), .id_valid(val_v[2]),
        .if_id_we(we_v[2]), .pc_we(pc_v[2]), .bubble(bub_v[2]),
        .stalled(stl_v[2]), .stall_cycles(c_sc), .stall_events(c_se)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 6'b000000};
    endfunction

    // Present one instruction to DUT d and hold it until it issues.
    task automatic run(input int d, input logic [15:0] ins, input logic v,
                       input int exp_bub, input string tag);
        int nb;
        nb = 0;
        ins_v[d] = ins;
        val_v[d] = v;
        @(negedge clk);
        while (bub_v[d] && nb < 10) begin
            nb++;
            @(negedge clk);
        end
        check({tag, "_bubbles"}, nb, exp_bub);
        check({tag, "_we"}, {30'd0, we_v[d], pc_v[d]}, 32'd3);
        check({tag, "_stalled"}, stl_v[d], (exp_bub > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        ins_v[d] = 16'h0000;
        val_v[d] = 1'b0;
    endtask

    task automatic flush();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ins_v[i] = 16'h0000;
            val_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_bubble", bub_v[0], 1);
        check("rst_if_id_we", we_v[0], 0);
        check("rst_pc_we", pc_v[0], 0);
        check("rst_stalled", stl_v[0], 0);
        check("rst_cycles", a_sc, 0);
        check("rst_events", a_se, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Independent instructions
        run(0, enc(4'h1, 2'd1, 2'd0, 2'd0), 1'b1, 0, "indep1");
        run(0, enc(4'h1, 2'd2, 2'd3, 2'd3), 1'b1, 0, "indep2");
        check("indep_cycles", a_sc, 0);

        // Distance-1 dependency
        flush();
        run(0, enc(4'h1, 2'd1, 2'd0, 2'd0), 1'b1, 0, "d1_add");
        run(0, enc(4'h2, 2'd2, 2'd1, 2'd0), 1'b1, 2, "d1_sub");
        check("d1_cycles", a_sc, 2);
        check("d1_events", a_se, 1);

        // Distance-2 dependency
        flush();
        run(0, enc(4'h6, 2'd2, 2'd0, 2'd0), 1'b1, 0, "d2_ld");
        run(0, 16'h0000, 1'b1, 0, "d2_nop");
        run(0, enc(4'h8, 2'd3, 2'd2, 2'd0), 1'b1, 1, "d2_mov");
        check("d2_cycles", a_sc, 3);
        check("d2_events", a_se, 2);

        // LDI reads nothing; ST reads both sources but adds no slot
        flush();
        run(0, enc(4'h1, 2'd1, 2'd0, 2'd0), 1'b1, 0, "ns_add");
        run(0, 16'h5455, 1'b1, 0, "ns_ldi");
        flush();
        run(0, enc(4'h1, 2'd2, 2'd0, 2'd0), 1'b1, 0, "st_add");
        run(0, enc(4'h7, 2'd0, 2'd1, 2'd2), 1'b1, 2, "st_st");
        run(0, enc(4'h8, 2'd3, 2'd0, 2'd0), 1'b1, 0, "st_noslot");
        check("st_cycles", a_sc, 5);
        check("st_events", a_se, 3);

        // id_valid low suppresses the hazard
        flush();
        run(0, enc(4'h1, 2'd1, 2'd0, 2'd0), 1'b1, 0, "iv_add");
        run(0, enc(4'h2, 2'd2, 2'd1, 2'd0), 1'b0, 0, "iv_sub");
        check("iv_cycles", a_sc, 5);

        // Reset during the first bubble
        flush();
        run(0, enc(4'h1, 2'd1, 2'd0, 2'd0), 1'b1, 0, "rm_add");
        ins_v[0] = enc(4'h2, 2'd2, 2'd1, 2'd0);
        val_v[0] = 1'b1;
        @(negedge clk);
        check("rm_first_bubble", bub_v[0], 1);
        #1 rst_n = 1'b0;
        #1;
        check("rm_bubble", bub_v[0], 1);
        check("rm_if_id_we", we_v[0], 0);
        check("rm_stalled", stl_v[0], 0);
        check("rm_cycles", a_sc, 0);
        check("rm_events", a_se, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rm_rel_bubble", bub_v[0], 0);
        check("rm_rel_if_id_we", we_v[0], 1);
        @(posedge clk);
        #1;
        val_v[0] = 1'b0;
        check("rm_rel_cycles", a_sc, 0);

        // No write-through: each stall is one bubble longer
        flush();
        run(1, enc(4'h1, 2'd1, 2'd0, 2'd0), 1'b1, 0, "nw_d1_add");
        run(1, enc(4'h2, 2'd2, 2'd1, 2'd0), 1'b1, 3, "nw_d1_sub");
        flush();
        run(1, enc(4'h6, 2'd2, 2'd0, 2'd0), 1'b1, 0, "nw_d2_ld");
        run(1, 16'h0000, 1'b1, 0, "nw_d2_nop");
        run(1, enc(4'h8, 2'd3, 2'd2, 2'd0), 1'b1, 2, "nw_d2_mov");
        check("nw_cycles", b_sc, 5);
        check("nw_events", b_se, 2);

        // Two-bit counters saturate
        flush();
        for (int k = 0; k < 5; k++) begin
            run(2, enc(4'h1, 2'd1, 2'd0, 2'd0), 1'b1, 0, "sat_add");
            run(2, enc(4'h2, 2'd2, 2'd1, 2'd0), 1'b1, 2, "sat_sub");
            if (k == 0) begin
                check("sat_first_cycles", c_sc, 2);
                check("sat_first_events", c_se, 1);
            end
        end
        check("sat_cycles", c_sc, 3);
        check("sat_events", c_se, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
